rect_mover: RTL and testbench
=============================

# rect_mover

Per-frame position generator for an on-screen rectangle sprite. Once per video frame, during vertical sync, it updates the sprite's x (left edge) and y (bottom edge, exclusive) coordinates. It sits directly upstream of the rectangle pixel generator. Two modes are supported: autonomous bouncing inside the screen bounds, and manual steering from debounced buttons. Coordinates are always clamped so that the whole sprite stays on screen.

## Interface
Parameters:
- SCREEN_W, 1024, visible width in pixels
- SCREEN_H, 768, visible height in lines
- WIDTH, 64, sprite width; must match the downstream rectangle
- HEIGHT, 64, sprite height; must match the downstream rectangle
- STEP, 4, pixels moved per frame per axis (1..63)
- X_INIT, 480, reset x
- Y_INIT, 416, reset y (bottom edge)

Ports:
- vclock  in  1  pixel clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high
- vsync  in  1  active-low vertical sync from the timing generator
- auto  in  1  1 = bounce mode, 0 = manual mode
- pause  in  1  1 = hold position this frame
- up, down, left, right  in  1 each  debounced, level-sensitive buttons
- x  out  11  sprite left edge, registered
- y  out  10  sprite bottom edge (exclusive), registered
- bounce  out  1  one-cycle pulse: a wall was hit this frame (auto mode only)

## Operation
- Legal ranges (invariant at all times): 0 <= x <= SCREEN_W-WIDTH; HEIGHT <= y <= SCREEN_H.
- Frame tick: vsync_d is the registered copy of vsync; the tick is vsync_d=1 and vsync=0 (falling edge). vsync_d resets to 0, so a vsync held low through reset never produces a tick.
- FSM states:
  - WAIT: on tick, latch auto and pause, then go to MOVE_X; otherwise stay.
  - MOVE_X: update x, then go to MOVE_Y.
  - MOVE_Y: update y, then go to DONE.
  - DONE: drive bounce, then go to WAIT.
- Ticks arriving outside WAIT are ignored.
- Arithmetic: candidate positions are computed in 12-bit signed form for both axes, so there is no wrap-around before clamping.
- Auto mode, per axis:
  - Candidate is pos + STEP when dir=+, pos - STEP when dir=-.
  - If the candidate falls outside the legal range, the position is set to the violated bound, dir toggles, and the per-frame hit flag is set.
  - Otherwise the position takes the candidate.
- Manual mode:
  - right alone moves x by +STEP; left alone by -STEP; both or neither leaves x unchanged.
  - down alone moves y by +STEP; up alone by -STEP; both or neither leaves y unchanged.
  - Results are clamped to the legal range. Direction registers do not change and the hit flag is never set.
- Buttons are sampled in the MOVE state that uses them.
- Latched pause=1: MOVE_X and MOVE_Y leave x, y, dir_x, dir_y unchanged; bounce stays 0.
- The hit flag clears on entry to MOVE_X.

## Timing
- Reset values: x=X_INIT, y=Y_INIT, dir_x=+, dir_y=+ (moving down), bounce=0, state=WAIT, vsync_d=0.
- If the tick is detected in cycle n:
  - state=MOVE_X in n+1; the new x is visible in n+2.
  - state=MOVE_Y in n+2; the new y is visible in n+3.
  - bounce=1 for exactly cycle n+3 (state DONE) if a hit occurred; state=WAIT in n+4.
- x and y are stable for the rest of the frame. Updates occur only during vsync, which is inside vertical blanking, so no torn sprite is drawn.
- Reset asserted in any state, including mid-MOVE, returns every register to its reset value on the next edge. A partial update is never retained.
- auto toggled mid-frame takes effect at the next tick; the dir registers keep their values across mode changes.
- Simultaneous hits on both axes in one frame still produce a single bounce pulse.

## Test plan
- Reset: hold reset 3 cycles with vsync=0 -> x=480, y=416, bounce=0; no update occurs after reset releases while vsync stays low.
- Auto step: auto=1, one vsync falling edge at cycle n -> x=484 at n+2, y=420 at n+3, bounce=0; after 10 frames x=520, y=456.
- Right wall: X_INIT=958, auto=1, one frame -> x=960, dir_x flips, bounce=1 for exactly cycle n+3; next frame x=956.
- Corner: X_INIT=958, Y_INIT=766 -> x=960, y=768, one bounce pulse; next frame x=956, y=764.
- Manual clamp: auto=0, X_INIT=2, Y_INIT=66, left=1 and up=1 for one frame -> x=0, y=64, bounce=0; left=right=1 -> x unchanged.
- Pause and reset: pause=1 at tick -> x, y unchanged; reset asserted during MOVE_Y -> x=480, y=416 on the next cycle and state=WAIT.

Source files
------------

// File: rtl/rect_mover.sv
// rect_mover: once per frame (vsync falling edge) advances a sprite's x/y position.
// Bounce mode reflects off the screen edges; manual mode steers from buttons with clamping.
module rect_mover #(
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768,
  parameter int WIDTH    = 64,
  parameter int HEIGHT   = 64,
  parameter int STEP     = 4,
  parameter int X_INIT   = 480,
  parameter int Y_INIT   = 416
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        auto,
  input  logic        pause,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        bounce
);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    MOVE_X = 2'd1,
    MOVE_Y = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic signed [11:0] X_LO   = 12'sd0;
  localparam logic signed [11:0] X_HI   = 12'(SCREEN_W - WIDTH);
  localparam logic signed [11:0] Y_LO   = 12'(HEIGHT);
  localparam logic signed [11:0] Y_HI   = 12'(SCREEN_H);
  localparam logic signed [11:0] STEP_S = 12'(STEP);

  // Signed per-frame displacement for one axis; dec/inc are the opposing buttons.
  function automatic logic signed [11:0] axis_delta(input logic am, input logic dir,
                                                    input logic dec, input logic inc);
    logic signed [11:0] d;
    if (am) begin
      d = dir ? STEP_S : -STEP_S;
    end else if (inc && !dec) begin
      d = STEP_S;
    end else if (dec && !inc) begin
      d = -STEP_S;
    end else begin
      d = 12'sd0;
    end
    return d;
  endfunction

  // Returns {violated, clamped value}; the violated bound is the clamped value.
  function automatic logic [12:0] clamp(input logic signed [11:0] c,
                                        input logic signed [11:0] lo,
                                        input logic signed [11:0] hi);
    logic [12:0] r;
    if (c < lo) begin
      r = {1'b1, lo};
    end else if (c > hi) begin
      r = {1'b1, hi};
    end else begin
      r = {1'b0, c};
    end
    return r;
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic               vsync_d_r;
  logic               auto_l_r;
  logic               pause_l_r;
  logic               dir_x_r;
  logic               dir_y_r;
  logic               hit_r;
  logic               bounce_r;
  logic [10:0]        x_r;
  logic [9:0]         y_r;
  logic               tick_s;
  logic signed [11:0] x_cand_s;
  logic signed [11:0] y_cand_s;
  logic [12:0]        x_clamp_s;
  logic [12:0]        y_clamp_s;

  assign tick_s = vsync_d_r & ~vsync;

  // Candidate positions and their clamped/violation results for both axes.
  always_comb begin
    x_cand_s  = $signed({1'b0, x_r}) + axis_delta(auto_l_r, dir_x_r, left, right);
    y_cand_s  = $signed({2'b00, y_r}) + axis_delta(auto_l_r, dir_y_r, up, down);
    x_clamp_s = clamp(x_cand_s, X_LO, X_HI);
    y_clamp_s = clamp(y_cand_s, Y_LO, Y_HI);
  end

  // Frame sequencer next-state: one tick walks MOVE_X, MOVE_Y, DONE back to WAIT.
  always_comb begin
    state_s = state_r;
    case (state_r)
      WAIT: begin
        if (tick_s) begin
          state_s = MOVE_X;
        end else begin
          state_s = WAIT;
        end
      end
      MOVE_X:  state_s = MOVE_Y;
      MOVE_Y:  state_s = DONE;
      DONE:    state_s = WAIT;
      default: state_s = WAIT;
    endcase
  end

  // State register.
  always_ff @(posedge vclock) begin
    if (reset) begin
      state_r <= WAIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Position, direction, hit and bounce registers updated in their move states.
  always_ff @(posedge vclock) begin
    if (reset) begin
      vsync_d_r <= 1'b0;
      auto_l_r  <= 1'b0;
      pause_l_r <= 1'b0;
      dir_x_r   <= 1'b1;
      dir_y_r   <= 1'b1;
      hit_r     <= 1'b0;
      bounce_r  <= 1'b0;
      x_r       <= 11'(X_INIT);
      y_r       <= 10'(Y_INIT);
    end else begin
      vsync_d_r <= vsync;
      bounce_r  <= 1'b0;
      case (state_r)
        WAIT: begin
          if (tick_s) begin
            auto_l_r  <= auto;
            pause_l_r <= pause;
            hit_r     <= 1'b0;
          end
        end
        MOVE_X: begin
          if (!pause_l_r) begin
            x_r <= x_clamp_s[10:0];
            if (auto_l_r && x_clamp_s[12]) begin
              dir_x_r <= ~dir_x_r;
              hit_r   <= 1'b1;
            end
          end
        end
        MOVE_Y: begin
          if (!pause_l_r) begin
            y_r <= y_clamp_s[9:0];
            if (auto_l_r && y_clamp_s[12]) begin
              dir_y_r <= ~dir_y_r;
              hit_r   <= 1'b1;
            end
            // Both axes hitting in one frame still collapse to one pulse.
            bounce_r <= hit_r | (auto_l_r & y_clamp_s[12]);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign x      = x_r;
  assign y      = y_r;
  assign bounce = bounce_r;

endmodule

// File: tb/tb_rect_mover.sv
// Randomized self-checking bench for rect_mover: three instances with different reset
// positions share stimulus and are compared every cycle against a frame-level model.
module tb_rect_mover;

  localparam int STEP = 4;
  localparam int XMIN = 0;
  localparam int XMAX = 960;
  localparam int YMIN = 64;
  localparam int YMAX = 768;

  logic clk = 1'b0;
  logic reset, vsync, auto, pause, up, down, left, right;
  logic [10:0] dx [3];
  logic [9:0]  dy [3];
  logic        db [3];

  int n_cmp = 0;
  int n_err = 0;
  int bcnt [3];

  int mx [3];
  int my [3];
  bit mdx [3];
  bit mdy [3];
  bit mb [3];
  bit mhit [3];
  int since;
  bit mvd, la, lp;
  bit mvalid = 1'b0;

  always #5 clk = ~clk;

  rect_mover #(.X_INIT(480), .Y_INIT(416)) u0 (
    .vclock(clk), .reset(reset), .vsync(vsync), .auto(auto), .pause(pause),
    .up(up), .down(down), .left(left), .right(right),
    .x(dx[0]), .y(dy[0]), .bounce(db[0]));
  rect_mover #(.X_INIT(958), .Y_INIT(766)) u1 (
    .vclock(clk), .reset(reset), .vsync(vsync), .auto(auto), .pause(pause),
    .up(up), .down(down), .left(left), .right(right),
    .x(dx[1]), .y(dy[1]), .bounce(db[1]));
  rect_mover #(.X_INIT(2), .Y_INIT(66)) u2 (
    .vclock(clk), .reset(reset), .vsync(vsync), .auto(auto), .pause(pause),
    .up(up), .down(down), .left(left), .right(right),
    .x(dx[2]), .y(dy[2]), .bounce(db[2]));

  function automatic int init_x(input int i);
    return (i == 0) ? 480 : (i == 1) ? 958 : 2;
  endfunction

  function automatic int init_y(input int i);
    return (i == 0) ? 416 : (i == 1) ? 766 : 66;
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // One axis of one frame: plain integer move, then clamp/reflect.
  function automatic void axis_move(input int pos, input bit dir, input int lo, input int hi,
                                    input bit am, input bit dec, input bit inc,
                                    output int np, output bit nd, output bit hit);
    int c;
    nd  = dir;
    hit = 1'b0;
    if (am) c = dir ? pos + STEP : pos - STEP;
    else if (inc && !dec) c = pos + STEP;
    else if (dec && !inc) c = pos - STEP;
    else c = pos;
    if (c < lo || c > hi) begin
      np = (c < lo) ? lo : hi;
      if (am) begin
        nd  = !dir;
        hit = 1'b1;
      end
    end else begin
      np = c;
    end
  endfunction

  // Reference model: since counts cycles elapsed after an accepted frame tick.
  initial begin
    since = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 3; i++) begin
          mx[i] = init_x(i); my[i] = init_y(i);
          mdx[i] = 1'b1; mdy[i] = 1'b1; mb[i] = 1'b0; mhit[i] = 1'b0;
        end
        since = 0; mvd = 1'b0; mvalid = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) mb[i] = 1'b0;
        if (since == 0) begin
          if (mvd && !vsync) begin
            la = auto; lp = pause; since = 1;
            for (int i = 0; i < 3; i++) mhit[i] = 1'b0;
          end
        end else if (since == 1) begin
          for (int i = 0; i < 3; i++) begin
            int np; bit nd, h;
            if (!lp) begin
              axis_move(mx[i], mdx[i], XMIN, XMAX, la, left, right, np, nd, h);
              mx[i] = np; mdx[i] = nd; mhit[i] = mhit[i] | h;
            end
          end
          since = 2;
        end else if (since == 2) begin
          for (int i = 0; i < 3; i++) begin
            int np; bit nd, h;
            if (!lp) begin
              axis_move(my[i], mdy[i], YMIN, YMAX, la, up, down, np, nd, h);
              my[i] = np; mdy[i] = nd; mhit[i] = mhit[i] | h;
              mb[i] = mhit[i];
            end
          end
          since = 3;
        end else begin
          since = 0;
        end
        mvd = vsync;
      end
    end
  end

  // Cycle-by-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        for (int i = 0; i < 3; i++) begin
          check($sformatf("x%0d", i), int'(dx[i]), mx[i]);
          check($sformatf("y%0d", i), int'(dy[i]), my[i]);
          check($sformatf("bounce%0d", i), int'(db[i]), int'(mb[i]));
          if (db[i]) bcnt[i]++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    vsync = 1'b1;
    cyc(2);
    vsync = 1'b0;
    cyc(6);
  endtask

  task automatic clear_bcnt();
    for (int i = 0; i < 3; i++) bcnt[i] = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; auto = 1'b0; pause = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    clear_bcnt();
    cyc(3);
    reset = 1'b0;
    cyc(5);
    check("rst_x0", int'(dx[0]), 480);
    check("rst_y0", int'(dy[0]), 416);
    check("rst_b0", int'(db[0]), 0);
    check("rst_x1", int'(dx[1]), 958);

    auto = 1'b1;
    clear_bcnt();
    frame();
    check("auto_x0", int'(dx[0]), 484);
    check("auto_y0", int'(dy[0]), 420);
    check("auto_bcnt0", bcnt[0], 0);
    check("corner_x1", int'(dx[1]), 960);
    check("corner_y1", int'(dy[1]), 768);
    check("corner_bcnt1", bcnt[1], 1);
    frame();
    check("corner2_x1", int'(dx[1]), 956);
    check("corner2_y1", int'(dy[1]), 764);
    repeat (8) frame();
    check("auto10_x0", int'(dx[0]), 520);
    check("auto10_y0", int'(dy[0]), 456);

    pulse_reset();
    auto = 1'b0; left = 1'b1; up = 1'b1;
    clear_bcnt();
    frame();
    check("man_x2", int'(dx[2]), 0);
    check("man_y2", int'(dy[2]), 64);
    check("man_x0", int'(dx[0]), 476);
    check("man_bcnt2", bcnt[2], 0);
    right = 1'b1; up = 1'b0;
    frame();
    check("both_x0", int'(dx[0]), 476);
    check("both_y0", int'(dy[0]), 412);
    left = 1'b0; right = 1'b0;

    auto = 1'b1;
    vsync = 1'b1;
    cyc(2);
    vsync = 1'b0; pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    cyc(5);
    check("pause_x0", int'(dx[0]), 476);
    check("pause_y0", int'(dy[0]), 412);

    vsync = 1'b1;
    cyc(2);
    vsync = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_x0", int'(dx[0]), 480);
    check("midrst_y0", int'(dy[0]), 416);
    cyc(3);
    frame();
    check("post_rst_x0", int'(dx[0]), 484);
    check("post_rst_y0", int'(dy[0]), 420);

    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 2) == 0) vsync = ~vsync;
      if ($urandom_range(0, 49) == 0) auto = ~auto;
      pause = ($urandom_range(0, 7) == 0);
      up    = $urandom_range(0, 1) != 0;
      down  = $urandom_range(0, 1) != 0;
      left  = $urandom_range(0, 1) != 0;
      right = $urandom_range(0, 1) != 0;
      reset = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
